// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, CPU-visible addresses and defaults.
// The overflow flag of uart_tx_buffered is enabled by defining UART_TX_OVERFLOW_FLAG_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [31:0] UART_ADDR        = 32'h0000_FF00;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_FF04;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

    // Word returned by a load from UART_STATUS_ADDR.
    function automatic logic [31:0] status_word(input logic busy, input logic full);
        return {30'b0, busy, full};
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side interface of the buffered UART transmitter.
// UART_TX_OVERFLOW_FLAG_EN adds the ovf/ovf_clr pair.
interface uart_tx_buffered_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             uart_tx;
`ifdef UART_TX_OVERFLOW_FLAG_EN
    logic             ovf_clr;
    logic             ovf;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, busy, count, uart_tx, ovf
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, busy, count, uart_tx, ovf
    );
`else
    modport master (
        output wr_en, wr_data,
        input  full, busy, count, uart_tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, busy, count, uart_tx
    );
`endif

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop in the same cycle frees room for a push.
module sync_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             drop
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign drop    = wr_en && !do_push;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU stores land in a FIFO, the FSM serialises LSB first.
// Defining UART_TX_OVERFLOW_FLAG_EN adds a sticky overflow flag with clear input.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_buffered_if.slave  bus
);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             pop_c;

    logic [7:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CNT_W-1:0] fifo_count;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop_c),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .drop    (fifo_drop)
    );

    // Next-state logic; a frame ending with data waiting chains straight into the next start bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.uart_tx = tx_q;
    assign bus.full    = fifo_full;
    assign bus.busy    = !fifo_empty || (state_q != IDLE);
    assign bus.count   = fifo_count;

`ifdef UART_TX_OVERFLOW_FLAG_EN
    logic ovf_q;

    // Sticky on any dropped write; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk) begin
        if (rst)              ovf_q <= 1'b0;
        else if (fifo_drop)   ovf_q <= 1'b1;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = fifo_drop;
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: serial-line decoder feeding a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         rx_ok_q[$];
    int         rx_start_q[$];

    int compared   = 0;
    int mismatched = 0;

    // Line decoder: samples every cycle, checks each bit is stable for CPB cycles.
    initial begin : line_monitor
        int         s;
        int         k;
        int         st;
        bit         active;
        bit         ok;
        logic [7:0] b;
        active = 1'b0; s = 0; k = 0; st = 0; ok = 1'b1; b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (bus.uart_tx === 1'b0) begin
                    active = 1'b1; s = 1; b = '0; ok = 1'b1; st = cyc;
                end
            end else begin
                if (s < CPB) begin
                    if (bus.uart_tx !== 1'b0) ok = 1'b0;
                end else if (s < 9 * CPB) begin
                    k = s / CPB - 1;
                    if (bus.uart_tx !== 1'b0 && bus.uart_tx !== 1'b1) ok = 1'b0;
                    if (s % CPB == 0) b[k] = bus.uart_tx;
                    else if (bus.uart_tx !== b[k]) ok = 1'b0;
                end else begin
                    if (bus.uart_tx !== 1'b1) ok = 1'b0;
                end
                s++;
                if (s == FRAME) begin
                    rx_q.push_back(b);
                    rx_ok_q.push_back(ok);
                    rx_start_q.push_back(st);
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Drives one write for exactly one edge; entered and left just after a falling edge.
    task automatic write_byte(input logic [7:0] d, output int edge_n);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        edge_n      = cyc + 1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit got);
        int i;
        i = 0;
        while (rx_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        got = (rx_q.size() >= n);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (bus.uart_tx !== 1'b1 || bus.full !== 1'b0 || bus.busy !== 1'b0 || bus.count !== '0) begin
            mismatched++;
            $display("FAIL reset_state: tx=%b full=%b busy=%b count=%0d, required tx=1 full=0 busy=0 count=0",
                     bus.uart_tx, bus.full, bus.busy, bus.count);
        end
`ifdef UART_TX_OVERFLOW_FLAG_EN
        compared++;
        if (bus.ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ovf: ovf=%b, required 0", bus.ovf);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n, st;
        bit got, ok;
        logic [7:0] r, e;
        repeat (3) @(negedge clk);
        write_byte(8'h55, n);
        exp_q.push_back(8'h55);
        compared++;
        if (bus.count !== 3'd1 || bus.uart_tx !== 1'b1) begin
            mismatched++;
            $display("FAIL single_enqueue: count=%0d tx=%b, required count=1 tx=1", bus.count, bus.uart_tx);
        end
        @(negedge clk);
        compared++;
        if (bus.count !== 3'd0 || bus.uart_tx !== 1'b0 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_latency: count=%0d tx=%b busy=%b, required count=0 tx=0 busy=1",
                     bus.count, bus.uart_tx, bus.busy);
        end
        wait_cycle(n + FRAME);
        compared++;
        if (bus.busy !== 1'b1 || bus.uart_tx !== 1'b1) begin
            mismatched++;
            $display("FAIL single_last_stop: busy=%b tx=%b, required busy=1 tx=1", bus.busy, bus.uart_tx);
        end
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_busy_fall: busy=%b, required 0", bus.busy);
        end
        wait_frames(1, 2 * FRAME, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL single_timeout: frames=%0d, required 1", rx_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); st = rx_start_q.pop_front();
            compared++;
            if (r !== e || !ok || st != n + 1) begin
                mismatched++;
                $display("FAIL single_frame: byte=%h ok=%b start=%0d, required byte=%h ok=1 start=%0d",
                         r, ok, st, e, n + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2, st, idx;
        bit got, ok;
        logic [7:0] r, e;
        repeat (2) @(negedge clk);
        write_byte(8'h41, n1);
        exp_q.push_back(8'h41);
        compared++;
        if (bus.count !== 3'd1) begin
            mismatched++;
            $display("FAIL b2b_count_a: count=%0d, required 1", bus.count);
        end
        write_byte(8'h42, n2);
        exp_q.push_back(8'h42);
        compared++;
        if (bus.count !== 3'd1) begin
            mismatched++;
            $display("FAIL b2b_count_b: count=%0d, required 1", bus.count);
        end
        wait_cycle(n1 + FRAME);
        compared++;
        if (bus.count !== 3'd1 || bus.uart_tx !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_before_pop: count=%0d tx=%b, required count=1 tx=1", bus.count, bus.uart_tx);
        end
        @(negedge clk);
        compared++;
        if (bus.count !== 3'd0 || bus.uart_tx !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_chained_start: count=%0d tx=%b, required count=0 tx=0", bus.count, bus.uart_tx);
        end
        wait_frames(2, 3 * FRAME, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL b2b_timeout: frames=%0d, required 2", rx_q.size());
        end
        idx = 0;
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); st = rx_start_q.pop_front();
            compared++;
            if (r !== e || !ok || st != n1 + 1 + idx * FRAME) begin
                mismatched++;
                $display("FAIL b2b_frame%0d: byte=%h ok=%b start=%0d, required byte=%h ok=1 start=%0d",
                         idx, r, ok, st, e, n1 + 1 + idx * FRAME);
            end
            idx++;
        end
    endtask

    task automatic test_overflow;
        int n, i;
        bit got, ok;
        logic [7:0] r, e;
        repeat (3) @(negedge clk);
        for (i = 0; i < 6; i++) begin
            write_byte(8'(8'hA0 + i), n);
            if (i < 5) exp_q.push_back(8'(8'hA0 + i));
            if (i == 4) begin
                compared++;
                if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
                    mismatched++;
                    $display("FAIL ovf_fill: full=%b count=%0d, required full=1 count=4", bus.full, bus.count);
                end
            end
        end
        compared++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
            mismatched++;
            $display("FAIL ovf_drop_count: full=%b count=%0d, required full=1 count=4", bus.full, bus.count);
        end
`ifdef UART_TX_OVERFLOW_FLAG_EN
        compared++;
        if (bus.ovf !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_set: ovf=%b, required 1", bus.ovf);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        compared++;
        if (bus.ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_clear: ovf=%b, required 0", bus.ovf);
        end
        bus.ovf_clr = 1'b1;
        write_byte(8'hEE, n);
        bus.ovf_clr = 1'b0;
        compared++;
        if (bus.ovf !== 1'b1 || bus.count !== 3'd4) begin
            mismatched++;
            $display("FAIL ovf_set_wins: ovf=%b count=%0d, required ovf=1 count=4", bus.ovf, bus.count);
        end
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
`endif
        wait_frames(5, 6 * FRAME, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL ovf_timeout: frames=%0d, required 5", rx_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); void'(rx_start_q.pop_front());
            compared++;
            if (r !== e || !ok) begin
                mismatched++;
                $display("FAIL ovf_frame: byte=%h ok=%b, required byte=%h ok=1", r, ok, e);
            end
        end
        repeat (CPB + 2) @(negedge clk);
        compared++;
        if (rx_q.size() != 0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_extra: extra_frames=%0d busy=%b, required 0 and busy=0", rx_q.size(), bus.busy);
        end
    endtask

    task automatic test_full_with_pop;
        int n0, n, s, i;
        bit got, ok;
        logic [7:0] r, e;
        repeat (2) @(negedge clk);
        for (i = 0; i < 5; i++) begin
            write_byte(8'(8'hB0 + i), n);
            if (i == 0) n0 = n;
            exp_q.push_back(8'(8'hB0 + i));
        end
        s = n0 + 1;
        wait_cycle(s + FRAME - 3);
        write_byte(8'hBE, n);
        compared++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1) begin
            mismatched++;
            $display("FAIL fullpop_drop: count=%0d full=%b, required count=4 full=1", bus.count, bus.full);
        end
        wait_cycle(s + FRAME - 1);
        write_byte(8'hB5, n);
        exp_q.push_back(8'hB5);
        compared++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.uart_tx !== 1'b0) begin
            mismatched++;
            $display("FAIL fullpop_accept: count=%0d full=%b tx=%b, required count=4 full=1 tx=0",
                     bus.count, bus.full, bus.uart_tx);
        end
`ifdef UART_TX_OVERFLOW_FLAG_EN
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
`endif
        wait_frames(6, 7 * FRAME, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL fullpop_timeout: frames=%0d, required 6", rx_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); void'(rx_start_q.pop_front());
            compared++;
            if (r !== e || !ok) begin
                mismatched++;
                $display("FAIL fullpop_frame: byte=%h ok=%b, required byte=%h ok=1", r, ok, e);
            end
        end
        repeat (CPB + 2) @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int n, s;
        bit got, ok;
        logic [7:0] r, e;
        repeat (2) @(negedge clk);
        write_byte(8'h33, n);
        s = n + 1;
        write_byte(8'h34, n);
        wait_cycle(s + 4 + 2 * CPB + 1);
        compared++;
        if (bus.uart_tx !== 1'b0 || bus.count !== 3'd1) begin
            mismatched++;
            $display("FAIL rstmid_bit2: tx=%b count=%0d, required tx=0 count=1", bus.uart_tx, bus.count);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.uart_tx !== 1'b1 || bus.count !== 3'd0 || bus.busy !== 1'b0 || bus.full !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_abort: tx=%b count=%0d busy=%b full=%b, required tx=1 count=0 busy=0 full=0",
                     bus.uart_tx, bus.count, bus.busy, bus.full);
        end
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        write_byte(8'hFF, n);
        exp_q.push_back(8'hFF);
        wait_frames(1, 2 * FRAME, got);
        compared++;
        if (!got) begin
            mismatched++;
            $display("FAIL rstmid_timeout: frames=%0d, required 1", rx_q.size());
        end
        while (exp_q.size() != 0 && rx_q.size() != 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); void'(rx_start_q.pop_front());
            compared++;
            if (r !== e || !ok) begin
                mismatched++;
                $display("FAIL rstmid_frame: byte=%h ok=%b, required byte=%h ok=1", r, ok, e);
            end
        end
        repeat (FRAME + 10) @(negedge clk);
        compared++;
        if (rx_q.size() != 0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_discard: extra_frames=%0d busy=%b, required 0 and busy=0", rx_q.size(), bus.busy);
        end
    endtask

    task automatic test_pointer_wrap;
        int n, g;
        bit got, ok;
        logic [7:0] r, e;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i), n);
            exp_q.push_back(8'(i));
            wait_frames(1, 2 * FRAME, got);
            compared++;
            if (!got) begin
                mismatched++;
                $display("FAIL wrap_timeout%0d: frames=%0d, required 1", i, rx_q.size());
            end
            while (exp_q.size() != 0 && rx_q.size() != 0) begin
                e = exp_q.pop_front(); r = rx_q.pop_front(); ok = rx_ok_q.pop_front(); void'(rx_start_q.pop_front());
                compared++;
                if (r !== e || !ok) begin
                    mismatched++;
                    $display("FAIL wrap_frame%0d: byte=%h ok=%b, required byte=%h ok=1", i, r, ok, e);
                end
            end
            g = 0;
            while (bus.busy !== 1'b0 && g < 4 * CPB) begin
                @(negedge clk);
                g++;
            end
            compared++;
            if (bus.busy !== 1'b0) begin
                mismatched++;
                $display("FAIL wrap_idle%0d: busy=%b, required 0", i, bus.busy);
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
`ifdef UART_TX_OVERFLOW_FLAG_EN
        bus.ovf_clr = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_with_pop();
        test_reset_midframe();
        test_pointer_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
